// File: rtl/pipe_controller.sv
// Pipelined main controller for the 5-stage MIPS core: decodes in D and carries
// the control word through E/M/W registers, resolving branches in Memory.
module pipe_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic                 ZeroM,
    input  logic                 FlushE,
    output logic                 RegDstE,
    output logic                 ALUSrcE,
    output logic [2:0]           ALUControlE,
    output logic                 MemWriteM,
    output logic                 PCSrcM,
    output logic                 RegWriteW,
    output logic                 MemToRegW,
    output logic                 JumpD,
    output logic                 IllegalOp,
    output logic [CNT_WIDTH-1:0] RetiredCount
);

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic       valid;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_e_reg;
    logic  illegal_d;
    logic  squash_e;

    logic  reg_write_m_reg;
    logic  branch_m_reg;
    logic  mem_write_m_reg;
    logic  mem_to_reg_m_reg;
    logic  valid_m_reg;

    logic  reg_write_w_reg;
    logic  mem_to_reg_w_reg;
    logic  valid_w_reg;

    logic                 illegal_reg;
    logic [CNT_WIDTH-1:0] retired_reg;

    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        JumpD     = 1'b0;
        unique case (Opcode)
            6'b000000: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.valid     = 1'b1;
                unique case (Funct)
                    6'b100000: ctrl_d.alu_ctrl = 3'b010;
                    6'b100010: ctrl_d.alu_ctrl = 3'b110;
                    6'b100100: ctrl_d.alu_ctrl = 3'b000;
                    6'b100101: ctrl_d.alu_ctrl = 3'b001;
                    6'b101010: ctrl_d.alu_ctrl = 3'b111;
                    default: begin
                        // unknown R-type function is treated exactly like a bad opcode
                        ctrl_d    = '0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            6'b100011: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.alu_ctrl   = 3'b010;
                ctrl_d.valid      = 1'b1;
            end
            6'b101011: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_ctrl  = 3'b010;
                ctrl_d.valid     = 1'b1;
            end
            6'b000100: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_ctrl = 3'b110;
                ctrl_d.valid    = 1'b1;
            end
            6'b001000: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = 3'b010;
                ctrl_d.valid     = 1'b1;
            end
            6'b000010: begin
                JumpD        = 1'b1;
                ctrl_d.valid = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    assign PCSrcM   = branch_m_reg & ZeroM;
    // a hazard flush and a taken branch collapse into one bubble load of E
    assign squash_e = FlushE | PCSrcM;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_e_reg       <= '0;
            reg_write_m_reg  <= 1'b0;
            branch_m_reg     <= 1'b0;
            mem_write_m_reg  <= 1'b0;
            mem_to_reg_m_reg <= 1'b0;
            valid_m_reg      <= 1'b0;
            reg_write_w_reg  <= 1'b0;
            mem_to_reg_w_reg <= 1'b0;
            valid_w_reg      <= 1'b0;
            illegal_reg      <= 1'b0;
            retired_reg      <= '0;
        end else begin
            ctrl_e_reg <= squash_e ? '0 : ctrl_d;

            if (PCSrcM) begin
                reg_write_m_reg  <= 1'b0;
                branch_m_reg     <= 1'b0;
                mem_write_m_reg  <= 1'b0;
                mem_to_reg_m_reg <= 1'b0;
                valid_m_reg      <= 1'b0;
            end else begin
                reg_write_m_reg  <= ctrl_e_reg.reg_write;
                branch_m_reg     <= ctrl_e_reg.branch;
                mem_write_m_reg  <= ctrl_e_reg.mem_write;
                mem_to_reg_m_reg <= ctrl_e_reg.mem_to_reg;
                valid_m_reg      <= ctrl_e_reg.valid;
            end

            reg_write_w_reg  <= reg_write_m_reg;
            mem_to_reg_w_reg <= mem_to_reg_m_reg;
            valid_w_reg      <= valid_m_reg;

            if (illegal_d && !squash_e)
                illegal_reg <= 1'b1;

            retired_reg <= retired_reg + {{(CNT_WIDTH-1){1'b0}}, valid_w_reg};
        end
    end

    assign RegDstE      = ctrl_e_reg.reg_dst;
    assign ALUSrcE      = ctrl_e_reg.alu_src;
    assign ALUControlE  = ctrl_e_reg.alu_ctrl;
    assign MemWriteM    = mem_write_m_reg;
    assign RegWriteW    = reg_write_w_reg;
    assign MemToRegW    = mem_to_reg_w_reg;
    assign IllegalOp    = illegal_reg;
    assign RetiredCount = retired_reg;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an instruction-level model.
module tb_pipe_controller;

    localparam int CW = 4;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic          clk;
    logic          reset;
    logic [5:0]    Opcode;
    logic [5:0]    Funct;
    logic          ZeroM;
    logic          FlushE;
    logic          RegDstE;
    logic          ALUSrcE;
    logic [2:0]    ALUControlE;
    logic          MemWriteM;
    logic          PCSrcM;
    logic          RegWriteW;
    logic          MemToRegW;
    logic          JumpD;
    logic          IllegalOp;
    logic [CW-1:0] RetiredCount;

    int checks = 0;
    int errors = 0;

    pipe_controller #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .ZeroM(ZeroM), .FlushE(FlushE), .RegDstE(RegDstE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .JumpD(JumpD),
        .IllegalOp(IllegalOp), .RetiredCount(RetiredCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // What an instruction means, straight from the opcode table.
    typedef struct packed {
        logic       rw;
        logic       rd;
        logic       as;
        logic [2:0] ac;
        logic       br;
        logic       mw;
        logic       mr;
        logic       v;
        logic       jmp;
        logic       ill;
    } instr_t;

    function automatic instr_t meaning(input logic [5:0] op, input logic [5:0] fn);
        instr_t w;
        w = '0;
        if (op == OP_R) begin
            w.rw = 1'b1; w.rd = 1'b1; w.v = 1'b1;
            if      (fn == 6'b100000) w.ac = 3'b010;
            else if (fn == 6'b100010) w.ac = 3'b110;
            else if (fn == 6'b100100) w.ac = 3'b000;
            else if (fn == 6'b100101) w.ac = 3'b001;
            else if (fn == 6'b101010) w.ac = 3'b111;
            else begin w = '0; w.ill = 1'b1; end
        end
        else if (op == OP_LW)   begin w.rw = 1'b1; w.as = 1'b1; w.mr = 1'b1; w.ac = 3'b010; w.v = 1'b1; end
        else if (op == OP_SW)   begin w.as = 1'b1; w.mw = 1'b1; w.ac = 3'b010; w.v = 1'b1; end
        else if (op == OP_BEQ)  begin w.br = 1'b1; w.ac = 3'b110; w.v = 1'b1; end
        else if (op == OP_ADDI) begin w.rw = 1'b1; w.as = 1'b1; w.ac = 3'b010; w.v = 1'b1; end
        else if (op == OP_J)    begin w.jmp = 1'b1; w.v = 1'b1; end
        else w.ill = 1'b1;
        return w;
    endfunction

    // Model: slot[0]=instruction in E, slot[1]=in M, slot[2]=in W.
    instr_t        slot [3];
    instr_t        dec_now;
    logic          taken_now;
    logic [CW-1:0] m_cnt;
    logic          m_ill;

    assign dec_now   = meaning(Opcode, Funct);
    assign taken_now = slot[1].br & ZeroM;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) slot[k] <= '0;
            m_cnt <= '0;
            m_ill <= 1'b0;
        end else begin
            slot[2] <= slot[1];
            slot[1] <= taken_now ? instr_t'(0) : slot[0];
            slot[0] <= (FlushE || taken_now || dec_now.ill) ? instr_t'(0) : dec_now;
            if (dec_now.ill && !FlushE && !taken_now) m_ill <= 1'b1;
            m_cnt <= m_cnt + CW'(slot[2].v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("RegDstE",      32'(RegDstE),      32'(slot[0].rd));
        chk("ALUSrcE",      32'(ALUSrcE),      32'(slot[0].as));
        chk("ALUControlE",  32'(ALUControlE),  32'(slot[0].ac));
        chk("MemWriteM",    32'(MemWriteM),    32'(slot[1].mw));
        chk("PCSrcM",       32'(PCSrcM),       32'(slot[1].br & ZeroM));
        chk("RegWriteW",    32'(RegWriteW),    32'(slot[2].rw));
        chk("MemToRegW",    32'(MemToRegW),    32'(slot[2].mr));
        chk("JumpD",        32'(JumpD),        32'(dec_now.jmp));
        chk("IllegalOp",    32'(IllegalOp),    32'(m_ill));
        chk("RetiredCount", 32'(RetiredCount), 32'(m_cnt));
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic fl);
        Opcode = op; Funct = fn; ZeroM = z; FlushE = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(OP_LW, 6'd0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [5:0] sweep_fn [5];
    logic [2:0] sweep_ac [5];
    int         rw_seen;

    initial begin
        sweep_fn[0] = 6'b100000; sweep_ac[0] = 3'b010;
        sweep_fn[1] = 6'b100010; sweep_ac[1] = 3'b110;
        sweep_fn[2] = 6'b100100; sweep_ac[2] = 3'b000;
        sweep_fn[3] = 6'b100101; sweep_ac[3] = 3'b001;
        sweep_fn[4] = 6'b101010; sweep_ac[4] = 3'b111;

        reset = 1'b0;
        drive(OP_LW, 6'd0, 1'b0, 1'b0);
        tick(); tick();
        chk("rst_alusrc", 32'(ALUSrcE), 0);
        chk("rst_aluctl", 32'(ALUControlE), 0);
        chk("rst_regwrw", 32'(RegWriteW), 0);
        chk("rst_memtor", 32'(MemToRegW), 0);
        chk("rst_count",  32'(RetiredCount), 0);
        reset = 1'b1;
        #1;
        chk("rel_alusrc", 32'(ALUSrcE), 0);
        chk("rel_count",  32'(RetiredCount), 0);

        // lw latency
        tick();
        chk("lw_alusrc", 32'(ALUSrcE), 1);
        chk("lw_aluctl", 32'(ALUControlE), 3'b010);
        chk("mdl_lw_e",  32'(slot[0].as), 1);
        idle();
        tick(); tick();
        chk("lw_memtorw", 32'(MemToRegW), 1);
        chk("lw_regwrw",  32'(RegWriteW), 1);
        tick();
        chk("lw_retired", 32'(RetiredCount), 1);

        // R-type sweep
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(OP_R, sweep_fn[i], 1'b0, 1'b0);
            tick();
            chk("rsweep_aluctl", 32'(ALUControlE), 32'(sweep_ac[i]));
            chk("rsweep_regdst", 32'(RegDstE), 1);
        end

        // taken branch: beq, add, add
        do_reset();
        drive(OP_BEQ, 6'd0, 1'b0, 1'b0); tick();
        drive(OP_R, F_ADD, 1'b0, 1'b0);  tick();
        drive(OP_R, F_ADD, 1'b1, 1'b0);  #1;
        chk("tk_pcsrc_hi", 32'(PCSrcM), 1);
        tick();
        idle(); #1;
        chk("tk_pcsrc_lo", 32'(PCSrcM), 0);
        rw_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            rw_seen += int'(RegWriteW);
        end
        chk("tk_regwrw_cnt", 32'(rw_seen), 0);
        chk("tk_retired",    32'(RetiredCount), 1);
        chk("mdl_tk_cnt",    32'(m_cnt), 1);

        // not-taken branch
        do_reset();
        drive(OP_BEQ, 6'd0, 1'b0, 1'b0); tick();
        drive(OP_R, F_ADD, 1'b0, 1'b0);  tick();
        drive(OP_R, F_ADD, 1'b0, 1'b0);  #1;
        chk("nt_pcsrc", 32'(PCSrcM), 0);
        tick();
        idle();
        rw_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            rw_seen += int'(RegWriteW);
        end
        chk("nt_regwrw_cnt", 32'(rw_seen), 2);
        chk("nt_retired",    32'(RetiredCount), 3);

        // flushed sw never writes memory nor retires; unflushed sw does write
        do_reset();
        drive(OP_SW, 6'd0, 1'b0, 1'b1); tick();
        rw_seen = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            tick();
            rw_seen += int'(MemWriteM);
        end
        chk("fl_memwr_cnt", 32'(rw_seen), 0);
        chk("fl_retired",   32'(RetiredCount), 0);
        drive(OP_SW, 6'd0, 1'b0, 1'b0); tick();
        idle(); tick();
        chk("sw_memwr", 32'(MemWriteM), 1);

        // illegal opcode, sticky
        do_reset();
        chk("ill_clear", 32'(IllegalOp), 0);
        drive(6'b111111, 6'd0, 1'b0, 1'b0); tick();
        chk("ill_set", 32'(IllegalOp), 1);
        for (int i = 0; i < 10; i++) begin
            drive(OP_ADDI, 6'd0, 1'b0, 1'b0);
            tick();
        end
        chk("ill_sticky", 32'(IllegalOp), 1);

        // 17 retirements wrap a 4-bit counter to 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(OP_ADDI, 6'd0, 1'b0, 1'b0);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();
        chk("wrap_count", 32'(RetiredCount), 1);

        // randomized traffic, compared every cycle by the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int sel;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                6: op = OP_BEQ;
                default: op = 6'($urandom);
            endcase
            if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
            else fn = sweep_fn[$urandom_range(0, 4)];
            drive(op, fn, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 99) < 2) reset = 1'b0;
            else reset = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Pipelined main controller for the 5-stage MIPS core. It decodes `Opcode`/`Funct` of the instruction in Decode and carries the resulting control word through Execute, Memory and Writeback control registers. It drives the datapath's stage-suffixed control inputs and resolves branches in Memory. It also supports bubble insertion, branch squash, an illegal-opcode flag and a retired-instruction counter.

## Interface
- `CNT_WIDTH`, 16, width of retired-instruction counter
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `Opcode`  input  6  InstrD[31:26] from datapath decoder
- `Funct`  input  6  InstrD[5:0]
- `ZeroM`  input  1  ALU zero flag, Memory stage
- `FlushE`  input  1  hazard request: load bubble into Execute at next edge
- `RegDstE`  output  1  1 = rd, 0 = rt
- `ALUSrcE`  output  1  1 = SignImmE
- `ALUControlE`  output  3  ALU operation
- `MemWriteM`  output  1  data memory write enable
- `PCSrcM`  output  1  BranchM & ZeroM
- `RegWriteW`  output  1  register file write enable
- `MemToRegW`  output  1  1 = ReadDataW
- `JumpD`  output  1  combinational, Decode-stage jump
- `IllegalOp`  output  1  sticky illegal-opcode flag
- `RetiredCount`  output  CNT_WIDTH  instructions completed in Writeback

## Operation
- Decode (combinational) produces the control word {RegWrite, RegDst, ALUSrc, ALUControl, Branch, MemWrite, MemToReg, Valid}. Unlisted fields are 0.
  - R-type 000000: RegWrite, RegDst, Valid. ALUControl from Funct: 100000 add→010, 100010 sub→110, 100100 and→000, 100101 or→001, 101010 slt→111. Any other Funct is illegal.
  - lw 100011: RegWrite, ALUSrc, MemToReg, ALUControl 010, Valid.
  - sw 101011: ALUSrc, MemWrite, ALUControl 010, Valid.
  - beq 000100: Branch, ALUControl 110, Valid.
  - addi 001000: RegWrite, ALUSrc, ALUControl 010, Valid.
  - j 000010: JumpD=1, Valid. No other fields set.
  - Any other opcode is illegal: the word is all-zero (bubble) and an illegal pulse is generated.
- Execute registers capture the Decode word each edge. They load all-zero instead when FlushE=1 or PCSrcM=1.
- Memory registers capture the Execute word (RegWrite, Branch, MemWrite, MemToReg, Valid). They load all-zero when PCSrcM=1, which squashes the instruction in Execute.
- Writeback registers capture the Memory word (RegWrite, MemToReg, Valid) unconditionally.
- PCSrcM = BranchM & ZeroM (combinational).
- IllegalOp sets at the edge where an illegal Decode instruction would enter Execute, provided FlushE=0 and PCSrcM=0. It stays set until reset.
- RetiredCount increments at each edge where ValidW=1. It wraps from 2^CNT_WIDTH−1 to 0.

## Timing
- Reset (reset=0, asynchronous) clears all E/M/W registers, IllegalOp and RetiredCount. Every registered output reads 0 while reset is held and immediately after release. JumpD stays purely combinational.
- Latency from Decode: E outputs valid +1 edge, M outputs +2, W outputs +3. An instruction retires (counter increment) on the edge after it reaches W, i.e. +4.
- FlushE and PCSrcM together act as a single flush. No double effect.
- When PCSrcM=1, the branch itself advances normally to W, with RegWrite=0 so nothing is written. The instructions in Execute and Decode become bubbles.
- A stall is modelled upstream: the datapath holds InstrD and asserts FlushE. The controller re-decodes the held instruction the next cycle.
- Reset asserted mid-operation discards all in-flight words at once. No partial retirement is counted.

## Test plan
- Reset: hold reset=0 with Opcode=100011 applied → all registered outputs 0 and RetiredCount=0. Release, apply lw → ALUSrcE=1 and ALUControlE=010 after 1 edge, MemToRegW=1 and RegWriteW=1 after 3 edges.
- R-type sweep: Funct 100000/100010/100100/100101/101010 on consecutive cycles → ALUControlE sequence 010,110,000,001,111 each one edge later, with RegDstE=1 throughout.
- Taken branch: beq followed by add, add with ZeroM=1 while beq is in M → PCSrcM=1 for one cycle. Both adds never raise RegWriteW. RetiredCount advances by 1 (beq only).
- Not-taken branch: same sequence with ZeroM=0 → PCSrcM=0, both adds retire, and RetiredCount advances by 3.
- FlushE: assert FlushE=1 during one sw → MemWriteM never asserts for that sw and its Valid does not reach W.
- Illegal/wrap: Opcode=111111 → IllegalOp=1 one edge later and stays 1 after 10 further legal instructions. With CNT_WIDTH=4, 17 retirements → RetiredCount=1.
